// File: rtl/layer_sequencer.sv
// Purpose: walks rows 0..NUM_ROWS-1 through the multiplier, captures each row sum and tracks the signed max / winning class.
// Latency: begin_mult follows start by 1 cycle; each result write and the next begin_mult follow done_row by 1 cycle.
// Backpressure: waits on done_row per row; aborts to ERR after TIMEOUT_CYCLES idle WAIT cycles; start ignored while busy.
module layer_sequencer #(
   parameter int NUM_ROWS       = 10,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int DATA_W         = 32
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   output logic              begin_mult,
   output logic [3:0]        row_select,
   input  logic              done_row,
   input  logic [DATA_W-1:0] row_result,
   input  logic              overflow,
   output logic              res_wr_en,
   output logic [3:0]        res_wr_addr,
   output logic [DATA_W-1:0] res_wr_data,
   output logic              busy,
   output logic              result_valid,
   output logic [3:0]        class_out,
   output logic [DATA_W-1:0] max_value,
   output logic              any_overflow,
   output logic              error
);

   localparam int              TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]      R_LAST = 4'(NUM_ROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE,
      S_ERR
   } state_t;

   state_t              state, state_nxt;
   logic [3:0]          row_idx, row_nxt;
   logic [TW-1:0]       timer, timer_nxt;

   logic                begin_mult_nxt;
   logic [3:0]          row_select_nxt;
   logic                wr_en_nxt;
   logic [3:0]          wr_addr_nxt;
   logic [DATA_W-1:0]   wr_data_nxt;
   logic                busy_nxt;
   logic                valid_nxt;
   logic [3:0]          class_nxt;
   logic [DATA_W-1:0]   max_nxt;
   logic                ovf_nxt;
   logic                err_nxt;

   // Next-state and next-output decode; every output is registered from these values.
   always_comb begin
      state_nxt   = state;
      row_nxt     = row_idx;
      timer_nxt   = timer;
      wr_en_nxt   = 1'b0;
      wr_addr_nxt = res_wr_addr;
      wr_data_nxt = res_wr_data;
      valid_nxt   = result_valid;
      class_nxt   = class_out;
      max_nxt     = max_value;
      ovf_nxt     = any_overflow;
      err_nxt     = error;

      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_nxt = S_ISSUE;
               row_nxt   = 4'd0;
               class_nxt = 4'd0;
               max_nxt   = '0;
               ovf_nxt   = 1'b0;
               err_nxt   = 1'b0;
               valid_nxt = 1'b0;
            end
         end
         S_ISSUE: begin
            // A done_row seen here belongs to no outstanding request and is dropped.
            state_nxt = S_WAIT;
            timer_nxt = '0;
         end
         S_WAIT: begin
            timer_nxt = timer + TW'(1);
            if (done_row) begin
               wr_en_nxt   = 1'b1;
               wr_addr_nxt = row_idx;
               wr_data_nxt = row_result;
               ovf_nxt     = any_overflow | overflow;
               // Strict greater-than so an equal later row never displaces the earlier one.
               if ((row_idx == 4'd0) || ($signed(row_result) > $signed(max_value))) begin
                  max_nxt   = row_result;
                  class_nxt = row_idx;
               end
               if (row_idx == R_LAST) begin
                  state_nxt = S_DONE;
                  valid_nxt = 1'b1;
               end else begin
                  row_nxt   = row_idx + 4'd1;
                  state_nxt = S_ISSUE;
               end
            end else if (timer == T_LAST) begin
               state_nxt = S_ERR;
               err_nxt   = 1'b1;
               valid_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      begin_mult_nxt = (state_nxt == S_ISSUE);
      busy_nxt       = (state_nxt == S_ISSUE) || (state_nxt == S_WAIT);
      row_select_nxt = row_nxt;
   end

   // State, counters and registered outputs; synchronous reset clears everything.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state        <= S_IDLE;
         row_idx      <= 4'd0;
         timer        <= '0;
         begin_mult   <= 1'b0;
         row_select   <= 4'd0;
         res_wr_en    <= 1'b0;
         res_wr_addr  <= 4'd0;
         res_wr_data  <= '0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         class_out    <= 4'd0;
         max_value    <= '0;
         any_overflow <= 1'b0;
         error        <= 1'b0;
      end else begin
         state        <= state_nxt;
         row_idx      <= row_nxt;
         timer        <= timer_nxt;
         begin_mult   <= begin_mult_nxt;
         row_select   <= row_select_nxt;
         res_wr_en    <= wr_en_nxt;
         res_wr_addr  <= wr_addr_nxt;
         res_wr_data  <= wr_data_nxt;
         busy         <= busy_nxt;
         result_valid <= valid_nxt;
         class_out    <= class_nxt;
         max_value    <= max_nxt;
         any_overflow <= ovf_nxt;
         error        <= err_nxt;
      end
   end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: behavioral multiplier answers 20 cycles after begin_mult,
// expected writes and pass results are queued at issue time and checked by a monitor.
module tb_layer_sequencer;

   logic        tb_clk;
   logic        n_rst;
   logic        start;
   logic        begin_mult;
   logic [3:0]  row_select;
   logic        done_row;
   logic [31:0] row_result;
   logic        overflow;
   logic        res_wr_en;
   logic [3:0]  res_wr_addr;
   logic [31:0] res_wr_data;
   logic        busy;
   logic        result_valid;
   logic [3:0]  class_out;
   logic [31:0] max_value;
   logic        any_overflow;
   logic        error;

   layer_sequencer #(
      .NUM_ROWS       (10),
      .TIMEOUT_CYCLES (1024),
      .DATA_W         (32)
   ) dut (
      .clk          (tb_clk),
      .n_rst        (n_rst),
      .start        (start),
      .begin_mult   (begin_mult),
      .row_select   (row_select),
      .done_row     (done_row),
      .row_result   (row_result),
      .overflow     (overflow),
      .res_wr_en    (res_wr_en),
      .res_wr_addr  (res_wr_addr),
      .res_wr_data  (res_wr_data),
      .busy         (busy),
      .result_valid (result_valid),
      .class_out    (class_out),
      .max_value    (max_value),
      .any_overflow (any_overflow),
      .error        (error)
   );

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   typedef struct {
      logic [3:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [3:0]  cls;
      logic [31:0] mx;
      logic        ovf;
      logic        err;
   } res_t;

   wr_t  exp_wr[$];
   res_t exp_res[$];

   int n_checks = 0;
   int n_fail   = 0;
   int bm_cnt   = 0;

   int         pat     = 1;
   logic       drop_en = 1'b0;
   logic [3:0] drop_row = 4'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] f(input int p, input logic [3:0] r);
      logic [31:0] rr;
      rr = 32'(r);
      case (p)
         2:       f = -(rr + 32'd1);
         3:       f = ((r == 4'd3) || (r == 4'd7)) ? 32'd500 : 32'd10;
         4:       f = rr + 32'd1;
         default: f = rr * 32'd100;
      endcase
   endfunction

   // Behavioral multiplier: done_row 20 cycles after a begin_mult pulse.
   initial begin : mult_model
      int         m_cnt;
      logic [3:0] m_row;
      m_cnt      = 0;
      m_row      = 4'd0;
      done_row   = 1'b0;
      row_result = 32'd0;
      overflow   = 1'b0;
      forever begin
         @(negedge tb_clk);
         done_row = 1'b0;
         overflow = 1'b0;
         if (m_cnt > 0) begin
            m_cnt--;
            if ((m_cnt == 0) && !(drop_en && (m_row == drop_row))) begin
               done_row   = 1'b1;
               row_result = f(pat, m_row);
               overflow   = (pat == 4) && (m_row == 4'd5);
            end
         end
         if (begin_mult === 1'b1) begin
            m_cnt = 20;
            m_row = row_select;
         end
      end
   end

   // Monitor: pops expected writes and pass results when the DUT presents them.
   initial begin : monitor
      logic prev_rv, prev_err;
      wr_t  w;
      res_t r;
      prev_rv  = 1'b0;
      prev_err = 1'b0;
      forever begin
         @(negedge tb_clk);
         if (begin_mult === 1'b1) bm_cnt++;
         if (res_wr_en === 1'b1) begin
            if (exp_wr.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL wr_unexpected: write addr %0d data %0h with none expected", res_wr_addr, res_wr_data);
            end else begin
               w = exp_wr.pop_front();
               check("wr_addr", 64'(res_wr_addr), 64'(w.addr));
               check("wr_data", 64'(res_wr_data), 64'(w.data));
            end
         end
         if (((result_valid === 1'b1) && !prev_rv) || ((error === 1'b1) && !prev_err)) begin
            if (exp_res.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL res_unexpected: result_valid %0b error %0b with none expected", result_valid, error);
            end else begin
               r = exp_res.pop_front();
               check("class_out",    64'(class_out),    64'(r.cls));
               check("max_value",    64'(max_value),    64'(r.mx));
               check("any_overflow", 64'(any_overflow), 64'(r.ovf));
               check("error",        64'(error),        64'(r.err));
               check("result_valid", 64'(result_valid), 64'(!r.err));
            end
         end
         prev_rv  = (result_valid === 1'b1);
         prev_err = (error === 1'b1);
      end
   end

   task automatic pulse_start();
      @(negedge tb_clk);
      start = 1'b1;
      @(negedge tb_clk);
      start = 1'b0;
   endtask

   task automatic run_pass(input int p, input int nwr, input int nbm,
                           input logic [3:0] cls, input logic [31:0] mx,
                           input logic ovf, input logic err);
      res_t r;
      int   base;
      int   k;
      pat = p;
      for (int i = 0; i < nwr; i++) exp_wr.push_back('{addr: 4'(i), data: f(p, 4'(i))});
      r = '{cls: cls, mx: mx, ovf: ovf, err: err};
      exp_res.push_back(r);
      base = bm_cnt;
      pulse_start();
      // A second start mid-pass must not disturb the running pass.
      repeat (30) @(negedge tb_clk);
      start = 1'b1;
      @(negedge tb_clk);
      start = 1'b0;
      k = 0;
      while (!((result_valid === 1'b1) || (error === 1'b1)) && (k < 3000)) begin
         @(negedge tb_clk);
         k++;
      end
      if (k >= 3000) begin
         n_checks++;
         n_fail++;
         $display("FAIL pass_timeout: pattern %0d never finished", p);
      end
      repeat (2) @(negedge tb_clk);
      check("writes_left",   64'(exp_wr.size()),  64'd0);
      check("results_left",  64'(exp_res.size()), 64'd0);
      check("begin_mult_cnt", 64'(bm_cnt - base), 64'(nbm));
      check("busy_end",      64'(busy),           64'd0);
      exp_wr.delete();
      exp_res.delete();
   endtask

   initial begin : stimulus
      int k;
      int base;
      n_rst = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge tb_clk);
      check("rst_ctrl", 64'({begin_mult, row_select, res_wr_en, res_wr_addr, busy,
                             result_valid, class_out, any_overflow, error}), 64'd0);
      check("rst_wr_data", 64'(res_wr_data), 64'd0);
      check("rst_max",     64'(max_value),   64'd0);
      n_rst = 1'b1;
      repeat (2) @(negedge tb_clk);

      // Ascending results: last row wins.
      run_pass(1, 10, 10, 4'd9, 32'd900, 1'b0, 1'b0);
      // All negative: row 0 (-1) is the signed maximum.
      run_pass(2, 10, 10, 4'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      // Tie between rows 3 and 7: lower index kept.
      run_pass(3, 10, 10, 4'd3, 32'd500, 1'b0, 1'b0);
      // Overflow flagged on row 5 only; still a full pass.
      run_pass(4, 10, 10, 4'd9, 32'd10, 1'b1, 1'b0);
      // Row 4 never answers: timeout after 4 writes with partial max.
      drop_en  = 1'b1;
      drop_row = 4'd4;
      run_pass(1, 4, 5, 4'd3, 32'd300, 1'b0, 1'b1);
      check("err_held",  64'(error),        64'd1);
      check("err_valid", 64'(result_valid), 64'd0);
      drop_en = 1'b0;
      // Recovery pass after error.
      run_pass(1, 10, 10, 4'd9, 32'd900, 1'b0, 1'b0);
      check("err_cleared", 64'(error), 64'd0);

      // Reset while waiting on row 2.
      pat = 1;
      exp_wr.push_back('{addr: 4'd0, data: 32'd0});
      exp_wr.push_back('{addr: 4'd1, data: 32'd100});
      base = bm_cnt;
      pulse_start();
      k = 0;
      while (!((busy === 1'b1) && (begin_mult === 1'b0) && (row_select == 4'd2)) && (k < 200)) begin
         @(negedge tb_clk);
         k++;
      end
      if (k >= 200) begin
         n_checks++;
         n_fail++;
         $display("FAIL row2_wait_timeout: never reached WAIT on row 2");
      end
      n_rst = 1'b0;
      @(negedge tb_clk);
      check("midrst_ctrl", 64'({begin_mult, row_select, res_wr_en, res_wr_addr, busy,
                                result_valid, class_out, any_overflow, error}), 64'd0);
      check("midrst_wr_data", 64'(res_wr_data), 64'd0);
      check("midrst_max",     64'(max_value),   64'd0);
      check("midrst_writes",  64'(exp_wr.size()), 64'd0);
      repeat (2) @(negedge tb_clk);
      n_rst = 1'b1;
      // Stale done_row for row 2 arrives in this window and must be ignored.
      repeat (40) @(negedge tb_clk);
      check("midrst_bm_cnt", 64'(bm_cnt - base), 64'd3);
      check("midrst_idle",   64'({busy, result_valid, res_wr_en}), 64'd0);
      // Normal full pass after reset.
      run_pass(1, 10, 10, 4'd9, 32'd900, 1'b0, 1'b0);

      repeat (5) @(negedge tb_clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
